// File: rtl/vram_sched.sv
// vram_sched: arbitrates screen, CPU and DMA accesses onto one asynchronous
// external SRAM. Every access takes a fixed four-cycle window
// (IDLE->ADDR->STRB1->STRB2). Screen fetches always have top priority.
// A small starvation counter lets DMA overtake a CPU that never stops asking.
module vram_sched #(
  parameter int AW           = 19,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk28,
  input  logic          rst_n,
  input  logic          scr_req,
  input  logic [AW-1:0] scr_addr,
  output logic [7:0]    scr_data,
  output logic          scr_valid,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [7:0]    dma_rdata,
  output logic [AW-1:0] va,
  input  logic [7:0]    vd_in,
  output logic [7:0]    vd_out,
  output logic          vd_oe,
  output logic          n_vwr,
  output logic          n_vrd,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ADDR, STRB1, STRB2} state_t;
  typedef enum logic [1:0] {OWN_SCR, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t        state;
  state_t        state_next;
  owner_t        owner;
  logic [AW-1:0] lat_addr;
  logic          lat_wr;
  logic [7:0]    lat_data;
  logic [2:0]    starve_cnt;
  logic          armed;

  logic          scr_elig;
  logic          cpu_elig;
  logic          dma_elig;
  logic          can_grant;
  logic          dma_urgent;
  logic          grant_scr;
  logic          grant_cpu;
  logic          grant_dma;
  logic          grant_any;
  logic [AW-1:0] sel_addr;
  logic          sel_wr;
  logic [7:0]    sel_data;

  // Arbitration. A requester whose strobe is high this cycle has just been
  // served, so it sits out this edge. Without that, a level request would
  // be granted a second time.
  always_comb begin
    scr_elig   = scr_req & ~scr_valid;
    cpu_elig   = cpu_req & ~cpu_ack;
    dma_elig   = dma_req & ~dma_ack;
    can_grant  = armed & (state == IDLE);
    dma_urgent = dma_elig & (starve_cnt == LIMIT);
    grant_scr  = can_grant & scr_elig;
    grant_dma  = can_grant & ~scr_elig & dma_elig & (dma_urgent | ~cpu_elig);
    grant_cpu  = can_grant & ~scr_elig & cpu_elig & ~dma_urgent;
    grant_any  = grant_scr | grant_cpu | grant_dma;
  end

  // Select the request fields of the winner. Screen fetches are always reads.
  always_comb begin
    sel_addr = scr_addr;
    sel_wr   = 1'b0;
    sel_data = 8'h00;
    if (grant_cpu) begin
      sel_addr = cpu_addr;
      sel_wr   = cpu_wr;
      sel_data = cpu_wdata;
    end else if (grant_dma) begin
      sel_addr = dma_addr;
      sel_wr   = dma_wr;
      sel_data = dma_wdata;
    end
  end

  // Next state: leave IDLE only on a grant, then step through the fixed window.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ADDR;
      ADDR:    state_next = STRB1;
      STRB1:   state_next = STRB2;
      STRB2:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. The async reset aborts any access in flight.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Block grants on the first edge after reset release, so the first edge
  // only arms the arbiter.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Capture the winning request. It stays frozen for the whole window.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= OWN_SCR;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      lat_data <= 8'h00;
    end else if (grant_any) begin
      owner    <= grant_scr ? OWN_SCR : (grant_cpu ? OWN_CPU : OWN_DMA);
      lat_addr <= sel_addr;
      lat_wr   <= sel_wr;
      lat_data <= sel_data;
    end
  end

  // Starvation counter. It counts CPU wins while DMA is waiting. Screen
  // grants leave it alone. It saturates so it can never wrap past the limit.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)                            starve_cnt <= 3'd0;
    else if (!dma_req || grant_dma)        starve_cnt <= 3'd0;
    else if (grant_cpu && starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
  end

  // Completion on the edge that leaves STRB2. Capture read data for the
  // owner and pulse its strobe for one cycle. Writes pulse ack only.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      scr_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      scr_data  <= 8'h00;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
    end else begin
      scr_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      if (state == STRB2) begin
        case (owner)
          OWN_SCR: begin
            scr_valid <= 1'b1;
            scr_data  <= vd_in;
          end
          OWN_CPU: begin
            cpu_ack <= 1'b1;
            if (!lat_wr) cpu_rdata <= vd_in;
          end
          default: begin
            dma_ack <= 1'b1;
            if (!lat_wr) dma_rdata <= vd_in;
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  // SRAM bus decode from the registered state. Because the decode is driven
  // straight from the state register, reset releases the strobes in the
  // same cycle that reset asserts.
  always_comb begin
    va     = '0;
    vd_out = 8'h00;
    vd_oe  = 1'b0;
    n_vwr  = 1'b1;
    n_vrd  = 1'b1;
    if (state != IDLE) begin
      va = lat_addr;
      if (lat_wr) begin
        vd_oe  = 1'b1;
        vd_out = lat_data;
        n_vwr  = ~((state == STRB1) | (state == STRB2));
      end else begin
        n_vrd = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_sched.sv
// tb_vram_sched: directed scenarios plus a randomized run of vram_sched.
// The randomized run is checked against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_vram_sched;

  localparam int AW    = 19;
  localparam int LIMIT = 4;

  logic          clk28 = 1'b0;
  logic          rst_n = 1'b0;
  logic          scr_req = 1'b0;
  logic [AW-1:0] scr_addr = '0;
  logic [7:0]    scr_data;
  logic          scr_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = 8'h00;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          dma_req = 1'b0;
  logic          dma_wr = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_wdata = 8'h00;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  logic [AW-1:0] va;
  logic [7:0]    vd_in = 8'h00;
  logic [7:0]    vd_out;
  logic          vd_oe;
  logic          n_vwr;
  logic          n_vrd;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  vram_sched #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_data(scr_data), .scr_valid(scr_valid),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .va(va), .vd_in(vd_in), .vd_out(vd_out), .vd_oe(vd_oe),
    .n_vwr(n_vwr), .n_vrd(n_vrd), .busy(busy)
  );

  // 10 ns clock period. The absolute rate does not matter to the bench.
  always #5 clk28 = ~clk28;

  // Reference model. The model counts clock edges. It keeps one access
  // record with the edge on which it was granted. Bus activity and
  // completion are then plain offsets from that grant edge:
  // +0..+2 on the bus, strobe after +3, next grant possible at +4.
  bit            m_armed;
  int            m_edge;
  bit            m_active;
  int            m_start;
  int            m_owner;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  bit            m_ack_s, m_ack_c, m_ack_d;
  logic [7:0]    m_rd_s, m_rd_c, m_rd_d;
  int            m_starve;
  bit            el_s, el_c, el_d, m_can;
  int            m_g;

  // Model update: one step per clock edge. Reset clears everything,
  // asynchronously.
  always @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      m_armed = 0; m_edge = 0; m_active = 0; m_start = 0; m_owner = 0;
      m_wr = 0; m_addr = '0; m_wdata = 8'h00;
      m_ack_s = 0; m_ack_c = 0; m_ack_d = 0;
      m_rd_s = 8'h00; m_rd_c = 8'h00; m_rd_d = 8'h00;
      m_starve = 0;
    end else begin
      m_edge++;
      el_s = scr_req && !m_ack_s;
      el_c = cpu_req && !m_ack_c;
      el_d = dma_req && !m_ack_d;
      m_can = m_armed && !(m_active && (m_edge - m_start) <= 3);
      m_ack_s = 0; m_ack_c = 0; m_ack_d = 0;
      if (m_active && (m_edge - m_start) == 3) begin
        m_active = 0;
        if (m_owner == 0) begin m_ack_s = 1; m_rd_s = vd_in; end
        else if (m_owner == 1) begin m_ack_c = 1; if (!m_wr) m_rd_c = vd_in; end
        else begin m_ack_d = 1; if (!m_wr) m_rd_d = vd_in; end
      end
      m_g = -1;
      if (m_can) begin
        if (el_s) m_g = 0;
        else if (el_d && m_starve == LIMIT) m_g = 2;
        else if (el_c) m_g = 1;
        else if (el_d) m_g = 2;
      end
      if (m_g >= 0) begin
        m_active = 1; m_start = m_edge; m_owner = m_g;
        if (m_g == 0) begin m_wr = 0; m_addr = scr_addr; m_wdata = 8'h00; end
        else if (m_g == 1) begin m_wr = cpu_wr; m_addr = cpu_addr; m_wdata = cpu_wdata; end
        else begin m_wr = dma_wr; m_addr = dma_addr; m_wdata = dma_wdata; end
      end
      if (!dma_req || m_g == 2) m_starve = 0;
      else if (m_g == 1 && m_starve < 7) m_starve++;
      m_armed = 1;
    end
  end

  // Drop all requests and wait, with a bound, until nothing is in flight.
  task automatic wait_idle();
    int cnt;
    cnt = 0;
    scr_req = 0; cpu_req = 0; dma_req = 0;
    @(negedge clk28);
    while ((busy || scr_valid || cpu_ack || dma_ack) && cnt < 20) begin
      @(negedge clk28);
      cnt++;
    end
    if (cnt >= 20) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL wait_idle: busy=%0b required 0 within 20 cycles", busy);
    end
    @(negedge clk28);
  endtask

  // Reset values, then first grant no earlier than the second edge after release.
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk28);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (va !== '0) begin n_fail++; $display("[TB] FAIL reset_va: got %h want 0", va); end
    n_cmp++; if (n_vwr !== 1'b1 || n_vrd !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_strobes: got n_vwr=%0b n_vrd=%0b want 1/1", n_vwr, n_vrd); end
    n_cmp++; if (vd_oe !== 1'b0 || vd_out !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_bus: got oe=%0b out=%h want 0/00", vd_oe, vd_out); end
    n_cmp++; if ({scr_valid, cpu_ack, dma_ack} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_acks: got %b want 000", {scr_valid, cpu_ack, dma_ack}); end
    n_cmp++; if ({scr_data, cpu_rdata, dma_rdata} !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 000000", {scr_data, cpu_rdata, dma_rdata}); end
    rst_n = 1;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h12345;
    @(negedge clk28);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL first_edge_no_grant: got busy=%0b want 0", busy); end
    @(negedge clk28);
    n_cmp++; if (busy !== 1'b1 || va !== 19'h12345) begin n_fail++; $display("[TB] FAIL second_edge_grant: got busy=%0b va=%h want 1/12345", busy, va); end
    repeat (3) @(negedge clk28);
    n_cmp++; if (cpu_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ack: got %0b want 1", cpu_ack); end
    cpu_req = 0;
  endtask

  // CPU write of 0x5A to 0x1C000: address, data and strobe timing.
  task automatic test_cpu_write();
    logic [AW-1:0] e_va;
    wait_idle();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h1C000; cpu_wdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk28);
      e_va = (i < 3) ? 19'h1C000 : '0;
      n_cmp++; if (va !== e_va) begin n_fail++; $display("[TB] FAIL wr_va[%0d]: got %h want %h", i, va, e_va); end
      n_cmp++; if (n_vwr !== ((i == 1 || i == 2) ? 1'b0 : 1'b1)) begin n_fail++; $display("[TB] FAIL wr_n_vwr[%0d]: got %0b", i, n_vwr); end
      n_cmp++; if (vd_oe !== (i < 3) || vd_out !== ((i < 3) ? 8'h5A : 8'h00)) begin n_fail++; $display("[TB] FAIL wr_bus[%0d]: got oe=%0b out=%h", i, vd_oe, vd_out); end
      n_cmp++; if (cpu_ack !== (i == 3)) begin n_fail++; $display("[TB] FAIL wr_ack[%0d]: got %0b want %0b", i, cpu_ack, (i == 3)); end
      n_cmp++; if (n_vrd !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_n_vrd[%0d]: got %0b want 1", i, n_vrd); end
      if (i == 3) cpu_req = 0;
    end
  endtask

  // CPU read of 0x00100 returning 0xA7; read data must hold afterwards.
  task automatic test_cpu_read();
    wait_idle();
    vd_in = 8'hA7;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h00100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk28);
      n_cmp++; if (n_vwr !== 1'b1 || vd_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_no_write[%0d]: got n_vwr=%0b oe=%0b want 1/0", i, n_vwr, vd_oe); end
      n_cmp++; if (n_vrd !== ((i < 3) ? 1'b0 : 1'b1)) begin n_fail++; $display("[TB] FAIL rd_n_vrd[%0d]: got %0b", i, n_vrd); end
      n_cmp++; if (cpu_ack !== (i == 3)) begin n_fail++; $display("[TB] FAIL rd_ack[%0d]: got %0b want %0b", i, cpu_ack, (i == 3)); end
      if (i >= 3) begin
        n_cmp++; if (cpu_rdata !== 8'hA7) begin n_fail++; $display("[TB] FAIL rd_data[%0d]: got %h want a7", i, cpu_rdata); end
      end
      if (i == 3) begin cpu_req = 0; vd_in = 8'h00; end
    end
  endtask

  // Three simultaneous requests: served screen, CPU, DMA, four cycles apart.
  task automatic test_priority();
    logic [AW-1:0] exp_addr [3];
    int n_s, n_c, n_d, t_s, t_c, t_d;
    exp_addr[0] = 19'h00A00; exp_addr[1] = 19'h00B00; exp_addr[2] = 19'h00C00;
    n_s = 0; n_c = 0; n_d = 0; t_s = -1; t_c = -1; t_d = -1;
    wait_idle();
    vd_in = 8'h66;
    scr_req = 1; scr_addr = exp_addr[0];
    cpu_req = 1; cpu_wr = 0; cpu_addr = exp_addr[1];
    dma_req = 1; dma_wr = 1; dma_addr = exp_addr[2]; dma_wdata = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk28);
      if (i % 4 == 0 && i < 12) begin
        n_cmp++; if (va !== exp_addr[i/4]) begin n_fail++; $display("[TB] FAIL prio_va[%0d]: got %h want %h", i, va, exp_addr[i/4]); end
      end
      if (scr_valid) begin n_s++; t_s = i; scr_req = 0; end
      if (cpu_ack) begin n_c++; t_c = i; cpu_req = 0; end
      if (dma_ack) begin n_d++; t_d = i; dma_req = 0; end
    end
    n_cmp++; if (n_s != 1 || t_s != 3) begin n_fail++; $display("[TB] FAIL prio_scr_valid: got count=%0d cycle=%0d want 1/3", n_s, t_s); end
    n_cmp++; if (n_c != 1 || t_c != 7) begin n_fail++; $display("[TB] FAIL prio_cpu_ack: got count=%0d cycle=%0d want 1/7", n_c, t_c); end
    n_cmp++; if (n_d != 1 || t_d != 11) begin n_fail++; $display("[TB] FAIL prio_dma_ack: got count=%0d cycle=%0d want 1/11", n_d, t_d); end
    n_cmp++; if (scr_data !== 8'h66 || cpu_rdata !== 8'h66 || dma_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL prio_rdata: got %h %h %h want 66 66 00", scr_data, cpu_rdata, dma_rdata); end
  endtask

  // All three requests are held. Screen and CPU alternate until CPU has
  // won four times. DMA is then served, and the counter restarts from zero.
  task automatic test_starvation();
    int seq [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};
    logic [AW-1:0] own_addr [3];
    int cpu_before_dma;
    bit dma_seen;
    own_addr[0] = 19'h00010; own_addr[1] = 19'h00020; own_addr[2] = 19'h00030;
    cpu_before_dma = 0; dma_seen = 0;
    wait_idle();
    scr_req = 1; scr_addr = own_addr[0];
    cpu_req = 1; cpu_wr = 0; cpu_addr = own_addr[1];
    dma_req = 1; dma_wr = 0; dma_addr = own_addr[2];
    for (int i = 0; i < 48; i++) begin
      @(negedge clk28);
      if (i % 4 == 0) begin
        n_cmp++; if (va !== own_addr[seq[i/4]]) begin n_fail++; $display("[TB] FAIL starve_grant[%0d]: got va=%h want %h", i/4, va, own_addr[seq[i/4]]); end
      end
      if (cpu_ack && !dma_seen) cpu_before_dma++;
      if (dma_ack && !dma_seen) begin
        dma_seen = 1;
        n_cmp++; if (cpu_before_dma != LIMIT) begin n_fail++; $display("[TB] FAIL starve_count: got %0d cpu grants before dma want %0d", cpu_before_dma, LIMIT); end
      end
    end
    n_cmp++; if (!dma_seen) begin n_fail++; $display("[TB] FAIL starve_dma_served: got no dma_ack want one within 48 cycles"); end
  endtask

  // Reset during STRB1 of a write aborts it cleanly; a re-issued write works.
  task automatic test_reset_mid_write();
    wait_idle();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h2AAAA; cpu_wdata = 8'hC3;
    repeat (2) @(negedge clk28);
    n_cmp++; if (n_vwr !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_pre_n_vwr: got %0b want 0", n_vwr); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (n_vwr !== 1'b1 || busy !== 1'b0 || va !== '0 || vd_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_immediate: got n_vwr=%0b busy=%0b va=%h oe=%0b want 1/0/0/0", n_vwr, busy, va, vd_oe); end
    cpu_req = 0;
    @(negedge clk28);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk28);
      n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_ack[%0d]: got %0b want 0", i, cpu_ack); end
    end
    cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h2AAAA; cpu_wdata = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk28);
      n_cmp++; if (va !== ((i < 3) ? 19'h2AAAA : 19'h0) || cpu_ack !== (i == 3)) begin n_fail++; $display("[TB] FAIL reissue[%0d]: got va=%h ack=%0b", i, va, cpu_ack); end
      if (i == 3) cpu_req = 0;
    end
  endtask

  // Randomized traffic from all requesters, compared every cycle to the model.
  task automatic test_random();
    int k;
    logic [AW-1:0] e_va;
    bit e_oe, e_nvwr, e_nvrd;
    logic [7:0] e_vdo;
    wait_idle();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk28);
      k = m_edge - m_start;
      e_va = m_active ? m_addr : '0;
      e_oe = m_active && m_wr;
      e_vdo = e_oe ? m_wdata : 8'h00;
      e_nvwr = !(m_active && m_wr && k >= 1);
      e_nvrd = !(m_active && !m_wr);
      n_cmp++; if (va !== e_va) begin n_fail++; $display("[TB] FAIL rnd_va@%0d: got %h want %h", c, va, e_va); end
      n_cmp++; if (vd_oe !== e_oe) begin n_fail++; $display("[TB] FAIL rnd_oe@%0d: got %0b want %0b", c, vd_oe, e_oe); end
      n_cmp++; if (vd_out !== e_vdo) begin n_fail++; $display("[TB] FAIL rnd_vd_out@%0d: got %h want %h", c, vd_out, e_vdo); end
      n_cmp++; if (n_vwr !== e_nvwr) begin n_fail++; $display("[TB] FAIL rnd_n_vwr@%0d: got %0b want %0b", c, n_vwr, e_nvwr); end
      n_cmp++; if (n_vrd !== e_nvrd) begin n_fail++; $display("[TB] FAIL rnd_n_vrd@%0d: got %0b want %0b", c, n_vrd, e_nvrd); end
      n_cmp++; if (busy !== m_active) begin n_fail++; $display("[TB] FAIL rnd_busy@%0d: got %0b want %0b", c, busy, m_active); end
      n_cmp++; if ({scr_valid, cpu_ack, dma_ack} !== {m_ack_s, m_ack_c, m_ack_d}) begin n_fail++; $display("[TB] FAIL rnd_acks@%0d: got %b want %b", c, {scr_valid, cpu_ack, dma_ack}, {m_ack_s, m_ack_c, m_ack_d}); end
      n_cmp++; if (scr_data !== m_rd_s) begin n_fail++; $display("[TB] FAIL rnd_scr_data@%0d: got %h want %h", c, scr_data, m_rd_s); end
      n_cmp++; if (cpu_rdata !== m_rd_c) begin n_fail++; $display("[TB] FAIL rnd_cpu_rdata@%0d: got %h want %h", c, cpu_rdata, m_rd_c); end
      n_cmp++; if (dma_rdata !== m_rd_d) begin n_fail++; $display("[TB] FAIL rnd_dma_rdata@%0d: got %h want %h", c, dma_rdata, m_rd_d); end
      vd_in = 8'($urandom);
      if (!scr_req) begin
        if ($urandom_range(0, 3) == 0) begin scr_req = 1; scr_addr = AW'($urandom); end
      end else if (m_ack_s) begin
        if ($urandom_range(0, 1) == 0) scr_req = 0; else scr_addr = AW'($urandom);
      end else if (!(m_active && m_owner == 0) && $urandom_range(0, 19) == 0) scr_req = 0;
      if (!cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin cpu_req = 1; cpu_wr = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom); end
      end else if (m_ack_c) begin
        if ($urandom_range(0, 2) == 0) cpu_req = 0;
        else begin cpu_wr = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom); end
      end else if (!(m_active && m_owner == 1) && $urandom_range(0, 19) == 0) cpu_req = 0;
      if (!dma_req) begin
        if ($urandom_range(0, 2) == 0) begin dma_req = 1; dma_wr = 1'($urandom); dma_addr = AW'($urandom); dma_wdata = 8'($urandom); end
      end else if (m_ack_d) begin
        if ($urandom_range(0, 2) == 0) dma_req = 0;
        else begin dma_wr = 1'($urandom); dma_addr = AW'($urandom); dma_wdata = 8'($urandom); end
      end else if (!(m_active && m_owner == 2) && $urandom_range(0, 19) == 0) dma_req = 0;
    end
  endtask

  // Test sequence.
  initial begin
    $display("[TB] vram_sched bench start");
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_priority();
    test_starvation();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
